// File: rtl/mul_div_unit.sv
// Multicycle MIPS multiply/divide unit with architectural HI/LO registers.
// Define MULDIV_FAST_MUL_EN to replace the shift-add multiply with a single-cycle multiplier.
module mul_div_unit #(
    parameter int ITER = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [5:0]  funct,
    input  logic        sign,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done
);

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MTLO  = 6'b010011;

    typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, FIX = 2'd3} state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [63:0] prod_q, prod_d;
    logic [31:0] opb_q, opb_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        qneg_q, qneg_d;
    logic        rneg_q, rneg_d;
    logic        is_div_q, is_div_d;
    logic        done_q, done_d;

    function automatic logic [31:0] cneg32(input logic [31:0] v, input logic en);
        return en ? -v : v;
    endfunction

    function automatic logic [63:0] cneg64(input logic [63:0] v, input logic en);
        return en ? -v : v;
    endfunction

    logic [31:0] abs_a, abs_b;
    logic        res_neg, rem_neg;
    logic [32:0] mul_sum;
    logic [32:0] div_sh;
    logic        div_ge;
    logic [31:0] div_diff;
    logic        last_iter;
    logic [63:0] prod_fix;

    assign abs_a   = (sign && a[31]) ? -a : a;
    assign abs_b   = (sign && b[31]) ? -b : b;
    assign res_neg = sign & (a[31] ^ b[31]);
    assign rem_neg = sign & a[31];

    // Multiply: prod_q = {partial product, remaining multiplier bits}, shifted right each step.
    assign mul_sum   = {1'b0, prod_q[63:32]} + (prod_q[0] ? {1'b0, opb_q} : 33'd0);
    // Divide: prod_q = {partial remainder, dividend bits still to shift / quotient bits}.
    assign div_sh    = {prod_q[63:32], prod_q[31]};
    assign div_ge    = div_sh >= {1'b0, opb_q};
    assign div_diff  = div_sh[31:0] - opb_q;
    assign last_iter = (cnt_q == 6'(ITER - 1));
    assign prod_fix  = cneg64(prod_q, qneg_q);

`ifdef MULDIV_FAST_MUL_EN
    logic [63:0] fast_prod;
    assign fast_prod = {32'd0, abs_a} * {32'd0, abs_b};
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        prod_d   = prod_q;
        opb_d    = opb_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        is_div_d = is_div_q;
        done_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    case (funct)
                        F_MULT, F_MULTU: begin
                            cnt_d    = 6'd0;
                            is_div_d = 1'b0;
                            rneg_d   = rem_neg;
`ifdef MULDIV_FAST_MUL_EN
                            prod_d   = cneg64(fast_prod, res_neg);
                            qneg_d   = 1'b0;
                            state_d  = FIX;
`else
                            prod_d   = {32'd0, abs_b};
                            opb_d    = abs_a;
                            qneg_d   = res_neg;
                            state_d  = MUL;
`endif
                        end
                        F_DIV, F_DIVU: begin
                            cnt_d    = 6'd0;
                            is_div_d = 1'b1;
                            prod_d   = {32'd0, abs_a};
                            opb_d    = abs_b;
                            qneg_d   = res_neg;
                            rneg_d   = rem_neg;
                            state_d  = DIV;
                        end
                        F_MTHI: hi_d = a;
                        F_MTLO: lo_d = a;
                        default: ;
                    endcase
                end
            end
            MUL: begin
                prod_d = {mul_sum, prod_q[31:1]};
                cnt_d  = cnt_q + 6'd1;
                if (last_iter) state_d = FIX;
            end
            DIV: begin
                prod_d = div_ge ? {div_diff, prod_q[30:0], 1'b1}
                                : {div_sh[31:0], prod_q[30:0], 1'b0};
                cnt_d  = cnt_q + 6'd1;
                if (last_iter) state_d = FIX;
            end
            FIX: begin
                if (is_div_q) begin
                    hi_d = cneg32(prod_q[63:32], rneg_q);
                    lo_d = cneg32(prod_q[31:0], qneg_q);
                end else begin
                    hi_d = prod_fix[63:32];
                    lo_d = prod_fix[31:0];
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= 6'd0;
            prod_q   <= 64'd0;
            opb_q    <= 32'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            is_div_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            prod_q   <= prod_d;
            opb_q    <= opb_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            is_div_q <= is_div_d;
            done_q   <= done_d;
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = (state_q != IDLE);
    assign done = done_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit (default or MULDIV_FAST_MUL_EN build).
module tb_mul_div_unit;

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MTLO  = 6'b010011;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_BUSY = 1;
    localparam logic [5:0] ABORT_F = F_DIV;
`else
    localparam int MUL_BUSY = 33;
    localparam logic [5:0] ABORT_F = F_MULT;
`endif
    localparam int DIV_BUSY = 33;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  funct = 6'd0;
    logic        sign = 1'b0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic [31:0] hi, lo;
    logic        busy, done;

    int checks = 0;
    int passed = 0;

    mul_div_unit #(.ITER(32)) dut (
        .clk(clk), .reset(reset), .start(start), .funct(funct), .sign(sign),
        .a(a), .b(b), .hi(hi), .lo(lo), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Issue at the current (negedge) point, then run until done or cycle budget expires.
    task automatic do_op(input logic [5:0] f, input logic [31:0] ia, input logic [31:0] ib,
                         output int busy_cyc, output bit got_done, output bit held);
        logic [31:0] h0, l0;
        start = 1'b1; funct = f; sign = ~f[0]; a = ia; b = ib;
        h0 = hi; l0 = lo;
        @(posedge clk); #1;
        start = 1'b0; funct = 6'd0;
        busy_cyc = 0; got_done = 1'b0; held = 1'b1;
        for (int i = 0; i < 100 && !got_done; i++) begin
            @(negedge clk);
            if (busy) busy_cyc++;
            if (done) got_done = 1'b1;
            else if (hi !== h0 || lo !== l0) held = 1'b0;
        end
    endtask

    task automatic test_reset;
        #1;
        checks++; if (hi !== 32'd0) $display("FAIL reset_hi: got %h expected %h", hi, 32'd0); else passed++;
        checks++; if (lo !== 32'd0) $display("FAIL reset_lo: got %h expected %h", lo, 32'd0); else passed++;
        checks++; if ({busy, done} !== 2'b00) $display("FAIL reset_busy_done: got %b expected 00", {busy, done}); else passed++;
        @(negedge clk); reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_multu;
        int bc; bit gd, hd;
        do_op(F_MULTU, 32'hFFFFFFFF, 32'h00000002, bc, gd, hd);
        checks++; if (!gd) $display("FAIL multu_done: got %b expected 1", gd); else passed++;
        checks++; if (hi !== 32'h00000001) $display("FAIL multu_hi: got %h expected %h", hi, 32'h1); else passed++;
        checks++; if (lo !== 32'hFFFFFFFE) $display("FAIL multu_lo: got %h expected %h", lo, 32'hFFFFFFFE); else passed++;
        checks++; if (bc != MUL_BUSY) $display("FAIL multu_busy_cycles: got %0d expected %0d", bc, MUL_BUSY); else passed++;
        checks++; if (!hd) $display("FAIL multu_hilo_held: got %b expected 1", hd); else passed++;
        @(negedge clk);
        checks++; if (done !== 1'b0) $display("FAIL multu_done_width: got %b expected 0", done); else passed++;
    endtask

    task automatic test_mult;
        int bc; bit gd, hd;
        do_op(F_MULT, 32'hFFFFFFFD, 32'd7, bc, gd, hd);
        checks++; if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFEB) $display("FAIL mult_neg: got %h expected %h", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB); else passed++;
        @(negedge clk);
        do_op(F_MULT, 32'h80000000, 32'hFFFFFFFF, bc, gd, hd);
        checks++; if ({hi, lo} !== 64'h00000000_80000000) $display("FAIL mult_min_neg1: got %h expected %h", {hi, lo}, 64'h80000000); else passed++;
        checks++; if (bc != MUL_BUSY) $display("FAIL mult_busy_cycles: got %0d expected %0d", bc, MUL_BUSY); else passed++;
        checks++; if (!gd) $display("FAIL mult_done: got %b expected 1", gd); else passed++;
        @(negedge clk);
    endtask

    task automatic test_div;
        int bc; bit gd, hd;
        do_op(F_DIV, 32'hFFFFFFF9, 32'd2, bc, gd, hd);
        checks++; if (lo !== 32'hFFFFFFFD) $display("FAIL div_quot: got %h expected %h", lo, 32'hFFFFFFFD); else passed++;
        checks++; if (hi !== 32'hFFFFFFFF) $display("FAIL div_rem: got %h expected %h", hi, 32'hFFFFFFFF); else passed++;
        checks++; if (bc != DIV_BUSY) $display("FAIL div_busy_cycles: got %0d expected %0d", bc, DIV_BUSY); else passed++;
        checks++; if (!hd) $display("FAIL div_hilo_held: got %b expected 1", hd); else passed++;
        @(negedge clk);
        do_op(F_DIV, 32'h80000000, 32'hFFFFFFFF, bc, gd, hd);
        checks++; if ({hi, lo} !== 64'h00000000_80000000) $display("FAIL div_overflow: got %h expected %h", {hi, lo}, 64'h80000000); else passed++;
        @(negedge clk);
        do_op(F_DIVU, 32'd100, 32'd7, bc, gd, hd);
        checks++; if ({hi, lo} !== {32'd2, 32'd14}) $display("FAIL divu_100_7: got %h expected %h", {hi, lo}, {32'd2, 32'd14}); else passed++;
        @(negedge clk);
    endtask

    task automatic test_div_by_zero;
        int bc; bit gd, hd;
        do_op(F_DIVU, 32'd7, 32'd0, bc, gd, hd);
        checks++; if ({hi, lo} !== {32'd7, 32'hFFFFFFFF}) $display("FAIL divu_zero: got %h expected %h", {hi, lo}, {32'd7, 32'hFFFFFFFF}); else passed++;
        @(negedge clk);
        do_op(F_DIV, 32'd9, 32'd0, bc, gd, hd);
        checks++; if ({hi, lo} !== {32'd9, 32'hFFFFFFFF}) $display("FAIL div_zero_pos: got %h expected %h", {hi, lo}, {32'd9, 32'hFFFFFFFF}); else passed++;
        @(negedge clk);
        do_op(F_DIV, 32'hFFFFFFFB, 32'd0, bc, gd, hd);
        checks++; if ({hi, lo} !== {32'hFFFFFFFB, 32'd1}) $display("FAIL div_zero_neg: got %h expected %h", {hi, lo}, {32'hFFFFFFFB, 32'd1}); else passed++;
        @(negedge clk);
    endtask

    task automatic test_mthi_mtlo;
        start = 1'b1; funct = F_MTHI; a = 32'h12345678;
        @(posedge clk); #1;
        start = 1'b0; funct = 6'd0;
        checks++; if (hi !== 32'h12345678) $display("FAIL mthi_value: got %h expected %h", hi, 32'h12345678); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL mthi_busy: got %b expected 0", busy); else passed++;
        @(negedge clk);
        checks++; if (done !== 1'b0) $display("FAIL mthi_done: got %b expected 0", done); else passed++;
        start = 1'b1; funct = F_MTLO; a = 32'hCAFEF00D;
        @(posedge clk); #1;
        start = 1'b0; funct = 6'd0;
        checks++; if ({hi, lo} !== {32'h12345678, 32'hCAFEF00D}) $display("FAIL mtlo_value: got %h expected %h", {hi, lo}, {32'h12345678, 32'hCAFEF00D}); else passed++;
        @(negedge clk);
        start = 1'b1; funct = 6'b100000; a = 32'h0BADBEEF;
        @(posedge clk); #1;
        start = 1'b0; funct = 6'd0;
        checks++; if ({busy, hi, lo} !== {1'b0, 32'h12345678, 32'hCAFEF00D}) $display("FAIL other_funct_ignored: got %h expected %h", {busy, hi, lo}, {1'b0, 32'h12345678, 32'hCAFEF00D}); else passed++;
        @(negedge clk);
    endtask

    task automatic test_start_while_busy;
        bit gd;
        start = 1'b1; funct = F_DIVU; sign = 1'b0; a = 32'd100; b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0; funct = 6'd0;
        repeat (5) @(negedge clk);
        start = 1'b1; funct = F_MTHI; a = 32'hDEADBEEF;
        @(posedge clk); #1;
        funct = F_MULTU; a = 32'd3; b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0; funct = 6'd0;
        gd = 1'b0;
        for (int i = 0; i < 100 && !gd; i++) begin
            @(negedge clk);
            if (done) gd = 1'b1;
        end
        checks++; if (!gd) $display("FAIL busy_ignore_done: got %b expected 1", gd); else passed++;
        checks++; if ({hi, lo} !== {32'd2, 32'd14}) $display("FAIL busy_ignore_result: got %h expected %h", {hi, lo}, {32'd2, 32'd14}); else passed++;
        @(negedge clk);
        checks++; if (busy !== 1'b0) $display("FAIL busy_ignore_idle: got %b expected 0", busy); else passed++;
    endtask

    task automatic test_back_to_back;
        int bc; bit gd, hd;
        do_op(F_MULTU, 32'd6, 32'd7, bc, gd, hd);
        checks++; if ({hi, lo} !== {32'd0, 32'd42}) $display("FAIL b2b_first: got %h expected %h", {hi, lo}, {32'd0, 32'd42}); else passed++;
        do_op(F_DIVU, 32'd50, 32'd8, bc, gd, hd);
        checks++; if ({hi, lo} !== {32'd2, 32'd6}) $display("FAIL b2b_second: got %h expected %h", {hi, lo}, {32'd2, 32'd6}); else passed++;
        checks++; if (bc != DIV_BUSY) $display("FAIL b2b_second_busy: got %0d expected %0d", bc, DIV_BUSY); else passed++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_op;
        int bc; bit gd, hd;
        start = 1'b1; funct = F_MTHI; a = 32'h55555555;
        @(posedge clk); #1;
        funct = F_MTLO; a = 32'hAAAAAAAA;
        @(posedge clk); #1;
        start = 1'b0; funct = 6'd0;
        @(negedge clk);
        start = 1'b1; funct = ABORT_F; sign = 1'b1; a = 32'h11111111; b = 32'h00000013;
        @(posedge clk); #1;
        start = 1'b0; funct = 6'd0;
        repeat (10) @(negedge clk);
        checks++; if (busy !== 1'b1) $display("FAIL abort_busy_before: got %b expected 1", busy); else passed++;
        #2 reset = 1'b1;
        #1;
        checks++; if ({busy, hi, lo} !== 65'd0) $display("FAIL abort_async_clear: got %h expected %h", {busy, hi, lo}, 65'd0); else passed++;
        @(negedge clk); reset = 1'b0;
        gd = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) gd = 1'b1;
        end
        checks++; if (gd !== 1'b0) $display("FAIL abort_no_done: got %b expected 0", gd); else passed++;
        do_op(F_MULTU, 32'd3, 32'd5, bc, gd, hd);
        checks++; if ({hi, lo} !== {32'd0, 32'd15}) $display("FAIL after_abort_multu: got %h expected %h", {hi, lo}, {32'd0, 32'd15}); else passed++;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_multu();
        test_mult();
        test_div();
        test_div_by_zero();
        test_mthi_mtlo();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Multicycle multiply/divide unit with architectural HI/LO registers for the MIPS datapath. It sits beside the ALU and is driven by the same decode path: the ALU controller's `Sign` output and the instruction `Funct` field select the operation. Results go to HI/LO for MFHI/MFLO. `busy` stalls the pipeline while an iterative operation is in flight.

## Interface
Parameters:
- `ITER`, default 32: iteration count for shift-add and restoring divide; must equal the operand width.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  issue strobe; sampled only when `busy`=0.
- `funct`  in  6  operation select:
  - 6'b011000 MULT
  - 6'b011001 MULTU
  - 6'b011010 DIV
  - 6'b011011 DIVU
  - 6'b010001 MTHI
  - 6'b010011 MTLO
  - any other value: `start` is ignored.
- `sign`  in  1  1 = signed operands; driven by the ALU controller (equals ~funct[0] for mult/div codes).
- `a`  in  32  rs operand: multiplicand, dividend, or MTHI/MTLO data.
- `b`  in  32  rt operand: multiplier or divisor.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.
- `busy`  out  1  high while in any state other than IDLE.
- `done`  out  1  one-cycle pulse when HI/LO are updated by MULT/DIV.

## Operation
- States: IDLE, MUL, DIV, FIX.
- IDLE with `start`=1 and a mult/div funct:
  - Latch |a| and |b| when `sign`=1; latch raw values when `sign`=0.
  - Latch the result-sign flags: product/quotient sign = a[31]^b[31]; remainder sign = a[31]. Both flags are 0 when unsigned.
  - Clear the 6-bit counter and go to MUL or DIV.
- MUL: radix-2 shift-add into a 64-bit accumulator, one multiplier bit per cycle. After `ITER` iterations go to FIX.
- DIV: restoring division, one quotient bit per cycle, with a 33-bit partial-remainder subtract. After `ITER` iterations go to FIX.
- FIX:
  - Conditionally two's-complement the results. Multiply: negate the 64-bit product. Divide: negate the quotient and remainder independently.
  - Write `{hi,lo}` = product, or `hi`=remainder and `lo`=quotient.
  - Pulse `done` and return to IDLE.
- MTHI/MTLO in IDLE with `start`: write `a` into `hi` or `lo` at that edge. No busy cycles, no `done`.
- Divide by zero: iterations run normally and yield HI=dividend (sign-corrected), LO=32'hFFFFFFFF for DIVU. For DIV with a≥0 the result is LO=32'hFFFFFFFF; with a<0 it is LO=32'h00000001. Results are deterministic; no exception is raised.
- Signed 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- `start` while `busy`=1 is ignored. The upstream stall logic must hold the instruction.
- `hi`/`lo` keep their previous values throughout MUL/DIV. They change only at the FIX→IDLE edge or on an MTHI/MTLO write.

## Timing
- Reset values: `hi`=0, `lo`=0, `busy`=0, `done`=0, state=IDLE, counter=0.
- Reset asserted mid-operation aborts immediately. HI/LO clear to 0 and no `done` is produced.
- Edge E0 samples `start`. `busy` is 1 from just after E0 until just after E(ITER+1).
- The iterations occupy edges E1..E32. FIX is the cycle after E32, and HI/LO update at E33.
- `done`=1 during the cycle following E33. Total latency from issue to valid HI/LO is 33 edges.
- A new `start` is accepted at E33+1 at the earliest, in the same cycle `done` is high.
- MTHI/MTLO: the value is visible on `hi`/`lo` one edge after issue.

## Configuration
- `MULDIV_FAST_MUL_EN` defined:
  - MULT/MULTU use a single-cycle 32×32 combinational multiply plus a sign fix in the same cycle.
  - State goes IDLE→FIX→IDLE, so HI/LO update at E1, `busy` is high for one cycle, and `done` is high in the cycle after E1.
  - Divide is unchanged.
- `MULDIV_FAST_MUL_EN` undefined: the iterative 33-edge multiply described above.

## Test plan
- MULTU a=32'hFFFFFFFF, b=32'h00000002 → at E33: hi=32'h00000001, lo=32'hFFFFFFFE, `done` for 1 cycle, `busy` high for 33 cycles.
- MULT a=-3 (32'hFFFFFFFD), b=7 → hi=32'hFFFFFFFF, lo=32'hFFFFFFEB.
- DIV a=-7, b=2 → lo=32'hFFFFFFFD (-3), hi=32'hFFFFFFFF (-1). Then DIVU a=7, b=0 → lo=32'hFFFFFFFF, hi=7.
- MTHI a=32'h12345678 with `busy`=0 → hi=32'h12345678 after one edge, `busy` stays 0, no `done`. A second `start` issued mid-DIV is ignored and the DIV result is unchanged.
- Reset pulsed at iteration 10 of a MULT → `busy`, `hi`, and `lo` read 0 asynchronously. A subsequent MULTU 3×5 gives lo=15, hi=0.
- With `MULDIV_FAST_MUL_EN`: MULT a=32'h80000000, b=-1 → hi=0, lo=32'h80000000, `done` in the cycle after E1.
